// File: rtl/deferred_step_batcher.sv
// Batches per-core difftest step counts into valid/ready requests for the host nstep bridge,
// firing on threshold, timeout, flush or first error result, and latching a sticky result.
module deferred_step_batcher #(
    parameter int NUM_CORES       = 1,
    parameter int STEP_WIDTH      = 8,
    parameter int ACC_WIDTH       = 16,
    parameter int BATCH_THRESHOLD = 64,
    parameter int TIMEOUT_CYCLES  = 256,
    parameter int RESULT_WIDTH    = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_CORES*STEP_WIDTH-1:0] step,
    input  logic                            flush,
    input  logic                            result_valid,
    input  logic [RESULT_WIDTH-1:0]         result_data,
    output logic                            nstep_valid,
    input  logic                            nstep_ready,
    output logic [NUM_CORES*ACC_WIDTH-1:0]  nstep_count,
    output logic [RESULT_WIDTH-1:0]         simv_result,
    output logic                            acc_overflow,
    output logic                            pending
);

    localparam int TMR_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int ACC_W1 = ACC_WIDTH + 1;
    localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [ACC_WIDTH:0] THR    = ACC_W1'(BATCH_THRESHOLD);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t                              r_state;
    state_t                              w_state_next;
    logic [NUM_CORES-1:0][ACC_WIDTH-1:0] r_acc;
    logic [NUM_CORES-1:0][ACC_WIDTH-1:0] w_acc_next;
    logic [NUM_CORES-1:0][ACC_WIDTH-1:0] r_count;
    logic [NUM_CORES-1:0]                w_clamp;
    logic [NUM_CORES-1:0]                w_thr_hit;
    logic [TMR_W-1:0]                    r_timer;
    logic [RESULT_WIDTH-1:0]             r_result;
    logic                                r_overflow;
    logic                                r_pending;
    logic                                w_err_new;
    logic                                w_timeout;
    logic                                w_trigger;
    logic                                w_snapshot;

    // Per-core saturating accumulator; a snapshot restarts it from this cycle's step.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
            logic [ACC_WIDTH:0] w_step_ext;
            logic [ACC_WIDTH:0] w_sum;

            assign w_step_ext     = {{(ACC_WIDTH - STEP_WIDTH + 1){1'b0}},
                                     step[gi*STEP_WIDTH +: STEP_WIDTH]};
            assign w_sum          = {1'b0, r_acc[gi]} + w_step_ext;
            assign w_clamp[gi]    = w_sum[ACC_WIDTH] && !w_snapshot;
            assign w_thr_hit[gi]  = ({1'b0, r_acc[gi]} >= THR);
            assign w_acc_next[gi] = w_snapshot       ? w_step_ext[ACC_WIDTH-1:0] :
                                    w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} :
                                                       w_sum[ACC_WIDTH-1:0];
            assign nstep_count[gi*ACC_WIDTH +: ACC_WIDTH] = r_count[gi];
        end
    endgenerate

    // A result only counts as new while no nonzero result has been latched yet.
    assign w_err_new = result_valid && (result_data != '0) && (r_result == '0);
    assign w_timeout = (r_timer >= TMR_MAX);
    assign w_trigger = (|w_thr_hit) || (r_pending && (w_timeout || flush || w_err_new));

    always_comb begin
        w_state_next = r_state;
        w_snapshot   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_state_next = ST_PEND;
                    w_snapshot   = 1'b1;
                end
            end
            ST_PEND: begin
                if (nstep_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_count   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_acc     <= w_acc_next;
            r_pending <= |w_acc_next;
            if (w_snapshot) begin
                r_count <= r_acc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timer    <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_snapshot) begin
                r_timer <= '0;
            end else if (!w_timeout) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_err_new) begin
                r_result <= result_data;
            end
            if (|w_clamp) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign nstep_valid  = (r_state == ST_PEND);
    assign simv_result  = r_result;
    assign acc_overflow = r_overflow;
    assign pending      = r_pending;

endmodule

// File: tb/tb_deferred_step_batcher.sv
// Self-checking bench for deferred_step_batcher: directed scenarios plus randomized traffic
// compared every cycle against an arithmetic reference model of the batching rules.
module tb_deferred_step_batcher;

    localparam int NC      = 2;
    localparam int SW      = 8;
    localparam int AW      = 10;
    localparam int THR     = 64;
    localparam int TO      = 100;
    localparam int RW      = 8;
    localparam int ACC_MAX = (1 << AW) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic [NC*SW-1:0]  step;
    logic              flush;
    logic              result_valid;
    logic [RW-1:0]     result_data;
    logic              nstep_valid;
    logic              nstep_ready;
    logic [NC*AW-1:0]  nstep_count;
    logic [RW-1:0]     simv_result;
    logic              acc_overflow;
    logic              pending;

    always #5 clock = ~clock;

    deferred_step_batcher #(
        .NUM_CORES      (NC),
        .STEP_WIDTH     (SW),
        .ACC_WIDTH      (AW),
        .BATCH_THRESHOLD(THR),
        .TIMEOUT_CYCLES (TO),
        .RESULT_WIDTH   (RW)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .step        (step),
        .flush       (flush),
        .result_valid(result_valid),
        .result_data (result_data),
        .nstep_valid (nstep_valid),
        .nstep_ready (nstep_ready),
        .nstep_count (nstep_count),
        .simv_result (simv_result),
        .acc_overflow(acc_overflow),
        .pending     (pending)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int     m_acc[NC];
    int     m_cnt[NC];
    int     m_timer = 0;
    int     m_res   = 0;
    bit     m_pend  = 0;
    bit     m_ovf   = 0;
    longint step_sum[NC];
    longint took_sum[NC];
    int     n_batches = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the batching rules, applied to whatever inputs are currently driven.
    task automatic model_edge();
        bit trig;
        bit any;
        bit err_new;
        int sv;
        int sum;
        if (reset) begin
            foreach (m_acc[i]) begin
                m_acc[i] = 0;
                m_cnt[i] = 0;
            end
            m_timer = 0;
            m_res   = 0;
            m_pend  = 0;
            m_ovf   = 0;
            return;
        end
        any  = 0;
        trig = 0;
        foreach (m_acc[i]) begin
            if (m_acc[i] != 0) any = 1;
            if (m_acc[i] >= THR) trig = 1;
        end
        err_new = result_valid && (result_data != 0) && (m_res == 0);
        if (any && (m_timer >= TO || flush || err_new)) trig = 1;
        if (m_pend) trig = 0;
        if (m_pend && nstep_ready) m_pend = 0;
        else if (trig) m_pend = 1;
        foreach (m_acc[i]) begin
            sv = int'(step[i*SW +: SW]);
            if (trig) begin
                m_cnt[i] = m_acc[i];
                m_acc[i] = sv;
            end else begin
                sum = m_acc[i] + sv;
                if (sum > ACC_MAX) begin
                    m_acc[i] = ACC_MAX;
                    m_ovf    = 1;
                end else begin
                    m_acc[i] = sum;
                end
            end
        end
        if (trig) m_timer = 0;
        else if (m_timer < TO) m_timer = m_timer + 1;
        if (err_new) m_res = int'(result_data);
    endtask

    task automatic cyc(input int s0, input int s1, input bit fl, input bit rv,
                       input int rd, input bit rdy, input bit rs);
        bit hs;
        bit any;
        reset           = rs;
        step[0 +: SW]   = SW'(s0);
        step[SW +: SW]  = SW'(s1);
        flush           = fl;
        result_valid    = rv;
        result_data     = RW'(rd);
        nstep_ready     = rdy;
        hs = nstep_valid && rdy && !rs;
        if (hs) begin
            n_batches++;
            for (int i = 0; i < NC; i++) took_sum[i] += longint'(nstep_count[i*AW +: AW]);
            $display("batch %0d accepted: core0=%0d core1=%0d t=%0t", n_batches,
                     nstep_count[0 +: AW], nstep_count[AW +: AW], $time);
        end
        if (rs) begin
            for (int i = 0; i < NC; i++) begin
                step_sum[i] = 0;
                took_sum[i] = 0;
            end
        end else begin
            step_sum[0] += s0;
            step_sum[1] += s1;
        end
        @(posedge clock);
        #1;
        model_edge();
        any = 0;
        foreach (m_acc[i]) if (m_acc[i] != 0) any = 1;
        chk("valid", 32'(nstep_valid), 32'(m_pend));
        chk("count0", 32'(nstep_count[0 +: AW]), 32'(m_cnt[0]));
        chk("count1", 32'(nstep_count[AW +: AW]), 32'(m_cnt[1]));
        chk("simv", 32'(simv_result), 32'(m_res));
        chk("overflow", 32'(acc_overflow), 32'(m_ovf));
        chk("pending", 32'(pending), 32'(any));
        if (nstep_valid) chk("nonzero_batch", 32'(nstep_count != '0), 32'd1);
    endtask

    task automatic cons_check(input string tag);
        longint held;
        for (int i = 0; i < NC; i++) begin
            held = m_pend ? longint'(m_cnt[i]) : 0;
            if (!m_ovf) chk(tag, 32'(took_sum[i] + held + longint'(m_acc[i])), 32'(step_sum[i]));
        end
    endtask

    initial begin
        int first_valid;
        int first_cnt;
        int first_cnt1;
        int b0;
        int s0;
        int s1;
        foreach (m_acc[i]) begin
            m_acc[i]    = 0;
            m_cnt[i]    = 0;
            step_sum[i] = 0;
            took_sum[i] = 0;
        end
        reset = 1'b1; step = '0; flush = 1'b0; result_valid = 1'b0;
        result_data = '0; nstep_ready = 1'b0;

        repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
        chk("rst_valid", 32'(nstep_valid), 32'd0);
        chk("rst_count", 32'(nstep_count), 32'd0);
        chk("rst_simv", 32'(simv_result), 32'd0);
        chk("rst_ovf", 32'(acc_overflow), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);

        // Threshold: one step per cycle on core 0
        first_valid = -1; first_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            cyc(1, 0, 0, 0, 0, 1, 0);
            if (nstep_valid && first_valid < 0) begin
                first_valid = k;
                first_cnt   = int'(nstep_count[0 +: AW]);
            end
        end
        chk("thr_latency", 32'(first_valid), 32'd64);
        chk("thr_count", 32'(first_cnt), 32'd64);
        cons_check("thr_conserve");

        // Timeout: a single step of 3 then silence
        cyc(0, 0, 0, 0, 0, 1, 1);
        b0 = n_batches; first_valid = -1; first_cnt = 0;
        for (int k = 0; k < 140; k++) begin
            cyc((k == 0) ? 3 : 0, 0, 0, 0, 0, 1, 0);
            if (nstep_valid && first_valid < 0) begin
                first_valid = k;
                first_cnt   = int'(nstep_count[0 +: AW]);
            end
        end
        chk("to_latency", 32'(first_valid >= TO - 1 && first_valid <= TO + 1), 32'd1);
        chk("to_count", 32'(first_cnt), 32'd3);
        chk("to_batches", 32'(n_batches - b0), 32'd1);

        // Two cores {5,2}, bridge stalled for 50 cycles after the first valid
        cyc(0, 0, 0, 0, 0, 0, 1);
        first_valid = -1;
        for (int k = 0; k < 20 && first_valid < 0; k++) begin
            cyc(5, 2, 0, 0, 0, 0, 0);
            if (nstep_valid) first_valid = k;
        end
        chk("stall_latency", 32'(first_valid), 32'd13);
        for (int k = 0; k < 50; k++) begin
            cyc(5, 2, 0, 0, 0, 0, 0);
            first_cnt  = int'(nstep_count[0 +: AW]);
            first_cnt1 = int'(nstep_count[AW +: AW]);
            chk("stall_hold0", 32'(first_cnt), 32'd65);
            chk("stall_hold1", 32'(first_cnt1), 32'd26);
        end
        chk("stall_ovf", 32'(acc_overflow), 32'd0);
        repeat (4) cyc(0, 0, 0, 0, 0, 1, 0);
        cons_check("stall_conserve");

        // Result sequence 0x00, 0x02, 0x05 while steps are pending
        cyc(0, 0, 0, 0, 0, 0, 1);
        repeat (3) cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("res_zero", 32'(simv_result), 32'd0);
        cyc(0, 0, 0, 1, 2, 0, 0);
        chk("res_first", 32'(simv_result), 32'd2);
        chk("res_trigger", 32'(nstep_valid), 32'd1);
        cyc(0, 0, 0, 1, 5, 1, 0);
        chk("res_keep", 32'(simv_result), 32'd2);
        repeat (3) cyc(0, 0, 0, 0, 0, 1, 0);

        // Randomized traffic
        for (int k = 0; k < 2500; k++) begin
            s0 = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(0, 12));
            s1 = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(0, 12));
            cyc(s0, s1, $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
                int'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
                $urandom_range(0, 599) == 0);
        end
        cons_check("rand_conserve");

        // Saturation with the bridge stalled, then reset while a batch is pending
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) cyc(255, 255, 0, k == 2, 7, 0, 0);
        chk("sat_ovf", 32'(acc_overflow), 32'd1);
        chk("sat_simv", 32'(simv_result), 32'd7);
        chk("sat_valid", 32'(nstep_valid), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("rst2_valid", 32'(nstep_valid), 32'd0);
        chk("rst2_simv", 32'(simv_result), 32'd0);
        chk("rst2_ovf", 32'(acc_overflow), 32'd0);
        chk("rst2_pending", 32'(pending), 32'd0);
        chk("rst2_count", 32'(nstep_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
